dc_fifo_write_ctrl: RTL and testbench

DC_FIFO_WRITE_CTRL -- requirements
Module: dc_fifo_write_ctrl

---
 rtl/dc_fifo_pkg.sv | 22 ++
 rtl/dc_ptr_sync.sv | 23 ++
 rtl/dc_fifo_write_ctrl.sv | 54 +++++
 tb/tb_dc_fifo_write_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dc_fifo_pkg.sv
// dc_fifo_pkg: pointer helpers shared by the write and read sides of the dual-clock FIFO
package dc_fifo_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/dc_ptr_sync.sv
// dc_ptr_sync: two-stage synchronizer for a Gray pointer crossing clock domains
module dc_ptr_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s1, r_s2;

  // Capture the foreign pointer, then let a second stage absorb metastability
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end

  assign o_q = r_s2;
endmodule

// File: rtl/dc_fifo_write_ctrl.sv
// dc_fifo_write_ctrl: write-side pointer, flow control and occupancy for a dual-clock FIFO
module dc_fifo_write_ctrl
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  localparam int AW          = log2(BUFFER_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [BUFFER_DEPTH-1:0] write_pointer,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [AW-1:0]           write_gray,
  input  logic [AW-1:0]           read_gray_async,
  output logic [AW-1:0]           level
);
  logic [AW-1:0] r_wr_bin, r_wr_gray;
  logic          r_init;
  logic [AW-1:0] w_rd_sync, w_rd_bin, w_wr_bin_nxt;
  logic          w_full, w_xfer;

  dc_ptr_sync #(.WIDTH(AW)) u_rd_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (read_gray_async),
    .o_q  (w_rd_sync)
  );

  assign w_rd_bin      = AW'(gray2bin(32'(w_rd_sync)));
  // One slot stays empty so the slot under the write pointer is never unread data
  assign w_full        = (r_wr_bin + AW'(1)) == w_rd_bin;
  assign ready_out     = r_init && !w_full;
  assign w_xfer        = valid_in && ready_out;
  assign w_wr_bin_nxt  = r_wr_bin + AW'(w_xfer);
  assign level         = r_wr_bin - w_rd_bin;
  assign write_pointer = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1} << r_wr_bin;
  assign write_data    = data_in;
  assign write_gray    = r_wr_gray;

  // Advance the write index on a transfer and keep its Gray copy in step
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_init    <= 1'b0;
    end else begin
      r_wr_bin  <= w_wr_bin_nxt;
      r_wr_gray <= AW'(bin2gray(32'(w_wr_bin_nxt)));
      r_init    <= 1'b1;
    end
endmodule

// File: tb/tb_dc_fifo_write_ctrl.sv
// tb_dc_fifo_write_ctrl: model-checked directed test of the dual-clock FIFO write controller
module tb_dc_fifo_write_ctrl;
  localparam int D  = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [D-1:0]  write_pointer;
  logic [DW-1:0] write_data;
  logic [2:0]    write_gray;
  logic [2:0]    read_gray_async = '0;
  logic [2:0]    level;

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;

  int         m_wr;
  logic [2:0] m_s1, m_s2;
  logic       m_init;
  logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  dc_fifo_write_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .write_pointer   (write_pointer),
    .write_data      (write_data),
    .write_gray      (write_gray),
    .read_gray_async (read_gray_async),
    .level           (level)
  );

  always #5 clk = ~clk;

  function automatic int gray_index(input logic [2:0] g);
    int r;
    r = 0;
    for (int i = 0; i < D; i++) if (((i ^ (i >> 1)) & 7) == int'(g)) r = i;
    return r;
  endfunction

  function automatic int m_level();
    return (m_wr - gray_index(m_s2) + D) % D;
  endfunction

  function automatic logic m_ready();
    return m_init && (m_level() != D - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_wr   <= 0;
      m_s1   <= '0;
      m_s2   <= '0;
      m_init <= 1'b0;
    end else begin
      if (valid_in && m_ready()) m_wr <= (m_wr + 1) % D;
      m_s1   <= read_gray_async;
      m_s2   <= m_s1;
      m_init <= 1'b1;
    end

  always @(posedge clk)
    if (rstn && valid_in && ready_out) xfers <= xfers + 1;

  always @(negedge clk) begin
    chk("ready_out", int'(ready_out), int'(m_ready()));
    chk("level", int'(level), m_level());
    chk("write_pointer", int'(write_pointer), 1 << m_wr);
    chk("write_gray", int'(write_gray), (m_wr ^ (m_wr >> 1)) & 7);
    chk("write_data", int'(write_data), int'(data_in));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    read_gray_async = '0;
    valid_in = 1'b0;
    #1;
    chk("rst_ptr", int'(write_pointer), 1);
    chk("rst_gray", int'(write_gray), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(ready_out), 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rel_ready_pre", int'(ready_out), 0);
    tick();
    chk("rel_ready_post", int'(ready_out), 1);
  endtask

  initial begin
    int n0;
    logic [2:0] prev, hist;
    do_reset();
    n0 = xfers;
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 32'hA000_0000 + 32'(i);
      tick();
    end
    valid_in = 1'b0;
    chk("fill_xfers", xfers - n0, 7);
    chk("fill_ptr", int'(write_pointer), 8'h80);
    chk("fill_ready", int'(ready_out), 0);
    chk("fill_level", int'(level), 7);
    read_gray_async = 3'b001;
    tick();
    chk("rel_ready_1", int'(ready_out), 0);
    tick();
    chk("rel_ready_2", int'(ready_out), 1);
    chk("rel_level", int'(level), 6);
    valid_in = 1'b1;
    tick();
    chk("rel_ptr", int'(write_pointer), 8'h01);
    chk("rel_gray", int'(write_gray), 0);
    chk("rel_full", int'(ready_out), 0);
    for (int i = 0; i < 4; i++) begin
      data_in = ~data_in;
      tick();
      chk("stall_ptr", int'(write_pointer), 8'h01);
      chk("stall_gray", int'(write_gray), 0);
      chk("stall_level", int'(level), 7);
    end
    valid_in = 1'b0;
    read_gray_async = 3'b000;
    tick();
    tick();
    chk("catchup_level", int'(level), 0);
    n0 = xfers;
    prev = write_gray;
    hist = write_gray;
    valid_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 32'(k * 7);
      tick();
      chk("wrap_gray", int'(write_gray), int'(gtab[(k + 1) % 8]));
      chk("wrap_onebit", $countones(write_gray ^ prev), 1);
      read_gray_async = hist;
      hist = prev;
      prev = write_gray;
    end
    valid_in = 1'b0;
    chk("wrap_xfers", xfers - n0, 20);
    do_reset();
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    valid_in = 1'b0;
    chk("mid_ptr", int'(write_pointer), 8'h10);
    do_reset();
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    valid_in = 1'b0;
    chk("sim_level0", int'(level), 6);
    read_gray_async = 3'b001;
    tick();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("sim_level1", int'(level), 6);
    chk("sim_ready1", int'(ready_out), 1);
    tick();
    tick();
    chk("sim_level2", int'(level), 6);
    chk("sim_ready2", int'(ready_out), 1);
    chk("sim_ptr", int'(write_pointer), 8'h80);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1);
  end
endmodule
